// File: rtl/beat_interval_bpm_if.sv
// BPM result channel: averaged BPM on valid/ready, plus lock flag and accepted-beat pulse.
// master drives the result; slave consumes it and applies backpressure through bpm_ready.
interface beat_interval_bpm_if #(
  parameter int BPM_WIDTH = 16
);
  logic [BPM_WIDTH-1:0] bpm_out;
  logic                 bpm_valid;
  logic                 bpm_ready;
  logic                 locked;
  logic                 beat_pulse_out;

  modport master (output bpm_out, bpm_valid, locked, beat_pulse_out, input bpm_ready);
  modport slave  (input bpm_out, bpm_valid, locked, beat_pulse_out, output bpm_ready);
endinterface

// File: rtl/beat_interval_bpm.sv
// Beat-to-beat interval tracker: outlier rejection, HIST_DEPTH average, 32-cycle divide to BPM.
// Result valid 35 cycles after an accepted edge; bpm_valid holds until taken, a newer result overwrites.
module beat_interval_bpm #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BPM_WIDTH  = 16,
  parameter int HIST_DEPTH = 4,
  parameter int MIN_BPM    = 40,
  parameter int MAX_BPM    = 200,
  parameter int TOL_SHIFT  = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                beat_in,
  beat_interval_bpm_if.master bpm_if
);
  localparam int          LOG2    = $clog2(HIST_DEPTH);
  localparam int          SUM_W   = 32 + LOG2;
  localparam logic [63:0] K64     = 64'(CLOCK_FREQ) * 64'd60;
  localparam logic [63:0] MAXI64  = K64 / 64'(MIN_BPM);
  localparam logic [63:0] MINI64  = K64 / 64'(MAX_BPM);
  localparam logic [31:0] K       = K64[31:0];
  localparam logic [31:0] MAX_INT = MAXI64[31:0];
  localparam logic [31:0] MIN_INT = MINI64[31:0];
  localparam logic [31:0] BPM_LO  = 32'(MIN_BPM);
  localparam logic [31:0] BPM_HI  = 32'(MAX_BPM);
  localparam logic [LOG2:0] FULL  = (LOG2 + 1)'(HIST_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 beat_q;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          hist_q [HIST_DEPTH];
  logic [31:0]          hist_d [HIST_DEPTH];
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [LOG2:0]        fill_q, fill_d;
  logic [LOG2-1:0]      wptr_q, wptr_d;
  logic [1:0]           rej_q, rej_d;
  logic [31:0]          int_q, int_d;
  logic [32:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [4:0]           step_q, step_d;
  logic [BPM_WIDTH-1:0] bpm_q, bpm_d;
  logic                 vld_q, vld_d;
  logic                 lock_q, lock_d;
  logic                 pulse_q, pulse_d;

  logic                 edge_w;
  logic [31:0]          avg_w;
  logic [31:0]          diff_w;
  logic                 in_tol_w;
  logic [32:0]          trial_w;
  logic                 trial_ge_w;
  logic [31:0]          clamp_w;
  logic [SUM_W-1:0]     oldest_w;
  logic [LOG2:0]        fill_next_w;

  assign edge_w     = beat_in & ~beat_q;
  assign avg_w      = 32'(sum_q >> LOG2);
  assign diff_w     = (cnt_q >= avg_w) ? (cnt_q - avg_w) : (avg_w - cnt_q);
  assign in_tol_w   = diff_w <= (avg_w >> TOL_SHIFT);
  assign trial_w    = {rem_q[31:0], quo_q[31]};
  assign trial_ge_w = trial_w >= {1'b0, avg_w};
  assign clamp_w    = (quo_q < BPM_LO) ? BPM_LO : ((quo_q > BPM_HI) ? BPM_HI : quo_q);
  // Until the ring is full the slot being written holds nothing that belongs to the sum.
  assign oldest_w    = (fill_q == FULL) ? SUM_W'(hist_q[wptr_q]) : '0;
  assign fill_next_w = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == MAX_INT) ? cnt_q : cnt_q + 32'd1;
    hist_d  = hist_q;
    sum_d   = sum_q;
    fill_d  = fill_q;
    wptr_d  = wptr_q;
    rej_d   = rej_q;
    int_d   = int_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    step_d  = step_q;
    bpm_d   = bpm_q;
    lock_d  = lock_q;
    pulse_d = 1'b0;
    vld_d   = (vld_q && bpm_if.bpm_ready) ? 1'b0 : vld_q;
    case (state_q)
      S_IDLE: begin
        if (edge_w && (cnt_q >= MIN_INT)) begin
          cnt_d = '0;
          if (cnt_q == MAX_INT) begin
            sum_d  = '0;
            fill_d = '0;
            wptr_d = '0;
            rej_d  = '0;
            lock_d = 1'b0;
          end else if ((fill_q < FULL) || in_tol_w) begin
            rej_d   = '0;
            pulse_d = 1'b1;
            int_d   = cnt_q;
            state_d = S_ACCEPT;
          end else if (rej_q == 2'd2) begin
            // Persistent disagreement means the tempo moved: restart history from this interval.
            sum_d   = '0;
            fill_d  = '0;
            wptr_d  = '0;
            rej_d   = '0;
            lock_d  = 1'b0;
            pulse_d = 1'b1;
            int_d   = cnt_q;
            state_d = S_ACCEPT;
          end else begin
            rej_d = rej_q + 2'd1;
          end
        end
      end
      S_ACCEPT: begin
        hist_d[wptr_q] = int_q;
        sum_d  = sum_q + SUM_W'(int_q) - oldest_w;
        wptr_d = wptr_q + 1'b1;
        fill_d = fill_next_w;
        if (fill_next_w == FULL) begin
          rem_d   = '0;
          quo_d   = K;
          step_d  = '0;
          state_d = S_DIVIDE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIVIDE: begin
        quo_d  = {quo_q[30:0], trial_ge_w};
        rem_d  = trial_ge_w ? (trial_w - {1'b0, avg_w}) : trial_w;
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) state_d = S_DONE;
      end
      default: begin
        bpm_d   = BPM_WIDTH'(clamp_w);
        vld_d   = 1'b1;
        lock_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      wptr_q  <= '0;
      rej_q   <= '0;
      int_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
      bpm_q   <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_in;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      wptr_q  <= wptr_d;
      rej_q   <= rej_d;
      int_q   <= int_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
      bpm_q   <= bpm_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
      pulse_q <= pulse_d;
    end
  end

  assign bpm_if.bpm_out        = bpm_q;
  assign bpm_if.bpm_valid      = vld_q;
  assign bpm_if.locked         = lock_q;
  assign bpm_if.beat_pulse_out = pulse_q;
endmodule

// File: tb/tb_beat_interval_bpm.sv
// Bench for beat_interval_bpm at CLOCK_FREQ=1000 (K=60000, intervals 300..1500 cycles).
// Expected BPM values are queued at stimulus time and checked by a handshake monitor.
module tb_beat_interval_bpm;
  logic CLOCK_50 = 1'b0;
  logic reset;
  logic beat_in;

  beat_interval_bpm_if #(.BPM_WIDTH(16)) bif ();

  beat_interval_bpm #(
    .CLOCK_FREQ(1000), .BPM_WIDTH(16), .HIST_DEPTH(4),
    .MIN_BPM(40), .MAX_BPM(200), .TOL_SHIFT(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .beat_in (beat_in),
    .bpm_if  (bif.master)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_v;
  int pulse_cnt = 0;
  int since_rise = 0;
  int p0;

  // Scoreboard monitor: every accepted result must match the oldest queued expectation.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (bif.beat_pulse_out) pulse_cnt++;
      if (bif.bpm_valid && bif.bpm_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL handshake_unexpected: got bpm_out=%0d, expected no result", bif.bpm_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (32'(bif.bpm_out) !== 32'(exp_v)) begin
            n_err++;
            $display("FAIL handshake_bpm: got %0d, expected %0d", bif.bpm_out, exp_v);
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge CLOCK_50);
    $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
      since_rise++;
    end
  endtask

  // Rising edge of beat_in placed 'pre' cycles after the previous rising edge.
  task automatic rise(input int pre);
    if (since_rise < pre) cyc(pre - since_rise);
    beat_in = 1'b1;
    since_rise = 0;
    cyc(3);
    beat_in = 1'b0;
  endtask

  task automatic rise_check(input int pre, input int exp, input bit early);
    rise(pre);
    cyc(31);
    if (early) chk("valid_before_35", 32'(bif.bpm_valid), 32'd0);
    cyc(1);
    chk("valid_at_35", 32'(bif.bpm_valid), 32'd1);
    chk("bpm_at_35", 32'(bif.bpm_out), 32'(exp));
    chk("locked_at_35", 32'(bif.locked), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    beat_in = 1'b0;
    bif.bpm_ready = 1'b1;
    cyc(2);
    chk("reset_bpm_out", 32'(bif.bpm_out), 32'd0);
    chk("reset_valid", 32'(bif.bpm_valid), 32'd0);
    chk("reset_locked", 32'(bif.locked), 32'd0);
    chk("reset_pulse", 32'(bif.beat_pulse_out), 32'd0);
    reset = 1'b0;

    // Steady 500-cycle beats: first beat is a timeout start, result after the 5th.
    cyc(1600);
    rise(0);
    for (int i = 0; i < 3; i++) rise(500);
    exp_q.push_back(120);
    rise_check(500, 120, 1'b1);
    chk("pulses_after_lock", 32'(pulse_cnt), 32'd4);

    // Debounce: a beat 100 cycles later is ignored, the next on-time beat is kept.
    p0 = pulse_cnt;
    rise(100);
    cyc(5);
    chk("debounce_no_pulse", 32'(pulse_cnt), 32'(p0));
    exp_q.push_back(120);
    rise_check(400, 120, 1'b1);
    chk("ontime_pulse", 32'(pulse_cnt), 32'(p0 + 1));

    // Backpressure: two results while not ready, the later one (avg 474 -> 126) wins.
    cyc(2);
    bif.bpm_ready = 1'b0;
    rise_check(500, 120, 1'b0);
    exp_q.push_back(126);
    rise_check(400, 126, 1'b0);
    bif.bpm_ready = 1'b1;
    cyc(1);
    chk("valid_drop_after_take", 32'(bif.bpm_valid), 32'd0);

    // Outliers: a lone 700 is rejected; three in a row restart history at 700 -> 85.
    p0 = pulse_cnt;
    rise(700);
    cyc(40);
    chk("reject_no_pulse", 32'(pulse_cnt), 32'(p0));
    chk("reject_bpm_held", 32'(bif.bpm_out), 32'd126);
    chk("reject_no_valid", 32'(bif.bpm_valid), 32'd0);
    exp_q.push_back(126);
    rise_check(500, 126, 1'b1);
    rise(700);
    rise(700);
    chk("two_rejects_locked", 32'(bif.locked), 32'd1);
    rise(700);
    chk("third_reject_unlock", 32'(bif.locked), 32'd0);
    rise(700);
    rise(700);
    exp_q.push_back(85);
    rise_check(700, 85, 1'b1);

    // Timeout: a 2000-cycle gap unlocks but keeps bpm_out; four new intervals relock.
    rise(2000);
    cyc(2);
    chk("timeout_unlock", 32'(bif.locked), 32'd0);
    chk("timeout_bpm_held", 32'(bif.bpm_out), 32'd85);
    for (int i = 0; i < 3; i++) rise(500);
    chk("refill_still_unlocked", 32'(bif.locked), 32'd0);
    exp_q.push_back(120);
    rise_check(500, 120, 1'b1);

    // Reset in the middle of the divide clears outputs immediately.
    rise(500);
    cyc(9);
    reset = 1'b1;
    #1;
    chk("midreset_bpm_out", 32'(bif.bpm_out), 32'd0);
    chk("midreset_valid", 32'(bif.bpm_valid), 32'd0);
    chk("midreset_locked", 32'(bif.locked), 32'd0);
    chk("midreset_pulse", 32'(bif.beat_pulse_out), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(1600);
    rise(0);
    for (int i = 0; i < 3; i++) rise(500);
    chk("relock_pending", 32'(bif.locked), 32'd0);
    exp_q.push_back(120);
    rise_check(500, 120, 1'b1);

    cyc(100);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
